// File: rtl/mux4_1.sv
// 4:1 lane mux built as a tree of mux2_1 cells, with combinational and registered outputs.
// Optional MUX4_1_HOLD_EN adds an `en` port that gates the output register update.

module mux2_1 #(
  parameter int WIDTH = 1
) (
  output logic [WIDTH-1:0]   out,
  input  logic [2*WIDTH-1:0] in,
  input  logic               sel
);
  assign out = sel ? in[WIDTH +: WIDTH] : in[0 +: WIDTH];
endmodule

module mux4_1 #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [4*WIDTH-1:0] in,
  input  logic [1:0]         sel,
`ifdef MUX4_1_HOLD_EN
  input  logic               en,
`endif
  output logic [WIDTH-1:0]   out,
  output logic [WIDTH-1:0]   out_q
);
  // stage-1 results packed as a two-lane bus so the final mux2_1 takes them directly
  logic [2*WIDTH-1:0] s1;
  logic [WIDTH-1:0]   out_d;

  mux2_1 #(.WIDTH(WIDTH)) u_lo (
    .out (s1[0 +: WIDTH]),
    .in  (in[2*WIDTH-1:0]),
    .sel (sel[0])
  );

  mux2_1 #(.WIDTH(WIDTH)) u_hi (
    .out (s1[WIDTH +: WIDTH]),
    .in  (in[4*WIDTH-1:2*WIDTH]),
    .sel (sel[0])
  );

  mux2_1 #(.WIDTH(WIDTH)) u_out (
    .out (out),
    .in  (s1),
    .sel (sel[1])
  );

  always_comb begin
`ifdef MUX4_1_HOLD_EN
    out_d = en ? out : out_q;
`else
    out_d = out;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_q <= '0;
    else        out_q <= out_d;
  end
endmodule

// File: tb/tb_mux4_1.sv
// Directed bench for mux4_1 (WIDTH=1 and WIDTH=8) and standalone mux2_1.
// Define MUX4_1_HOLD_EN at build time to also exercise the register enable.

module tb_mux4_1;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic [3:0]  in1 = '0;
  logic [1:0]  sel1 = '0;
  logic        out1, out_q1;
  logic [31:0] in8 = '0;
  logic [1:0]  sel8 = '0;
  logic [7:0]  out8, out_q8;
  logic [1:0]  in2 = '0;
  logic        sel2 = 1'b0;
  logic        out2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux4_1 #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in(in1), .sel(sel1),
`ifdef MUX4_1_HOLD_EN
    .en(en),
`endif
    .out(out1), .out_q(out_q1)
  );

  mux4_1 #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in(in8), .sel(sel8),
`ifdef MUX4_1_HOLD_EN
    .en(en),
`endif
    .out(out8), .out_q(out_q8)
  );

  mux2_1 #(.WIDTH(1)) u_m2 (.out(out2), .in(in2), .sel(sel2));

  typedef struct { logic [1:0] sel; logic [3:0] in; logic exp; } vec4_t;
  typedef struct { logic sel; logic [1:0] in; logic exp; } vec2_t;
  typedef struct { logic [1:0] sel; logic [7:0] exp; } vec8_t;

  vec4_t v4[6];
  vec2_t v2[8];
  vec8_t v8[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    v4[0] = '{sel: 2'd2, in: 4'b0100, exp: 1'b1};
    v4[1] = '{sel: 2'd3, in: 4'b0111, exp: 1'b0};
    v4[2] = '{sel: 2'd0, in: 4'b0001, exp: 1'b1};
    v4[3] = '{sel: 2'd1, in: 4'b0010, exp: 1'b1};
    v4[4] = '{sel: 2'd1, in: 4'b1101, exp: 1'b0};
    v4[5] = '{sel: 2'd3, in: 4'b1000, exp: 1'b1};

    v2[0] = '{sel: 1'b0, in: 2'b00, exp: 1'b0};
    v2[1] = '{sel: 1'b0, in: 2'b01, exp: 1'b1};
    v2[2] = '{sel: 1'b0, in: 2'b10, exp: 1'b0};
    v2[3] = '{sel: 1'b0, in: 2'b11, exp: 1'b1};
    v2[4] = '{sel: 1'b1, in: 2'b00, exp: 1'b0};
    v2[5] = '{sel: 1'b1, in: 2'b01, exp: 1'b0};
    v2[6] = '{sel: 1'b1, in: 2'b10, exp: 1'b1};
    v2[7] = '{sel: 1'b1, in: 2'b11, exp: 1'b1};

    v8[0] = '{sel: 2'd0, exp: 8'hAA};
    v8[1] = '{sel: 2'd1, exp: 8'hBB};
    v8[2] = '{sel: 2'd2, exp: 8'hCC};
    v8[3] = '{sel: 2'd3, exp: 8'hDD};

    // reset state, and out tracking inputs while in reset
    #2;
    check("reset_out_q1", {31'd0, out_q1}, 32'd0);
    check("reset_out_q8", {24'd0, out_q8}, 32'd0);
    in8 = 32'hDDCCBBAA; sel8 = 2'd1;
    #1;
    check("out8_in_reset", {24'd0, out8}, 32'h0000_00BB);
    @(posedge clk); #1;
    check("out_q8_held_by_reset", {24'd0, out_q8}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // standalone mux2_1
    for (int i = 0; i < 8; i++) begin
      sel2 = v2[i].sel; in2 = v2[i].in;
      #1;
      check($sformatf("mux2_vec%0d", i), {31'd0, out2}, {31'd0, v2[i].exp});
    end

    // WIDTH=1 hand vectors
    for (int i = 0; i < 6; i++) begin
      sel1 = v4[i].sel; in1 = v4[i].in;
      #1;
      check($sformatf("w1_vec%0d", i), {31'd0, out1}, {31'd0, v4[i].exp});
    end

    // WIDTH=1 full sweep of {sel,in}, 10 ns per step
    for (int k = 0; k < 64; k++) begin
      logic [5:0] sv;
      logic [3:0] iv;
      sv = k[5:0];
      iv = sv[3:0];
      sel1 = sv[5:4]; in1 = iv;
      #1;
      check($sformatf("w1_sweep%0d", k), {31'd0, out1}, {31'd0, iv[sv[5:4]]});
      #9;
    end

    // WIDTH=1 registered path: load then change input between edges
    @(negedge clk); sel1 = 2'd2; in1 = 4'b0100;
    @(posedge clk); #1;
    check("w1_out_q_load", {31'd0, out_q1}, 32'd1);
    in1 = 4'b0000;
    #1;
    check("w1_out_q_between_edges", {31'd0, out_q1}, 32'd1);
    @(posedge clk); #1;
    check("w1_out_q_reload", {31'd0, out_q1}, 32'd0);

    // WIDTH=8 lanes, out_q one clock behind
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); sel8 = v8[i].sel;
      #1;
      check($sformatf("w8_out_sel%0d", i), {24'd0, out8}, {24'd0, v8[i].exp});
      @(posedge clk); #1;
      check($sformatf("w8_out_q_sel%0d", i), {24'd0, out_q8}, {24'd0, v8[i].exp});
    end

    // asynchronous reset mid-cycle
    @(negedge clk); sel8 = 2'd2;
    @(posedge clk); #1;
    check("w8_pre_reset_cc", {24'd0, out_q8}, 32'h0000_00CC);
    #2; rst_n = 1'b0;
    #1;
    check("w8_async_reset_out_q", {24'd0, out_q8}, 32'd0);
    check("w8_async_reset_out", {24'd0, out8}, 32'h0000_00CC);
    @(negedge clk); rst_n = 1'b1;
    #1;
    check("w8_released_no_edge", {24'd0, out_q8}, 32'd0);
    @(posedge clk); #1;
    check("w8_first_edge_after_reset", {24'd0, out_q8}, 32'h0000_00CC);

`ifdef MUX4_1_HOLD_EN
    @(negedge clk); sel8 = 2'd0; en = 1'b1;
    @(posedge clk); #1;
    check("hold_load_aa", {24'd0, out_q8}, 32'h0000_00AA);
    @(negedge clk); en = 1'b0; sel8 = 2'd3;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("hold_keep_aa%0d", i), {24'd0, out_q8}, 32'h0000_00AA);
    end
    check("hold_out_comb", {24'd0, out8}, 32'h0000_00DD);
    @(negedge clk); en = 1'b1;
    @(posedge clk); #1;
    check("hold_release_dd", {24'd0, out_q8}, 32'h0000_00DD);
    @(negedge clk); en = 1'b0; rst_n = 1'b0;
    #1;
    check("hold_reset_overrides_en", {24'd0, out_q8}, 32'd0);
    @(negedge clk); rst_n = 1'b1; en = 1'b1;
`endif

    #10;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
